// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows for NB = 4, 6 or 8 columns.
// The transform feeds slot 1; later slots form an elastic valid/ready chain carrying a tag.
module shift_rows_pipe #(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_data,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int BW = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $fatal(1, "shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $fatal(1, "shift_rows_pipe: PIPE_STAGES must be 1..4");
  end
  if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag
    $fatal(1, "shift_rows_pipe: TAG_W must be 1..16");
  end

  // Wide blocks (NB = 8) skip one extra column on rows 2 and 3.
  function automatic int row_shift(input int r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  function automatic logic [BW-1:0] shift_rows(input logic [BW-1:0] d, input logic inv);
    logic [BW-1:0] res;
    int            src;
    res = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (inv) begin
          src = (c + NB - row_shift(r)) % NB;
        end else begin
          src = (c + row_shift(r)) % NB;
        end
        res[BW-1-8*(4*c+r) -: 8] = d[BW-1-8*(4*src+r) -: 8];
      end
    end
    return res;
  endfunction

  logic [PIPE_STAGES-1:0] valid_q, valid_d;
  logic [BW-1:0]          data_q [PIPE_STAGES];
  logic [BW-1:0]          data_d [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_d  [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] ready_s;
  logic [BW-1:0]          xform_s;

  assign xform_s = shift_rows(in_data, in_inv);

  // Combinational ready chain, walked from the output slot back to the input.
  always_comb begin
    logic rdy;
    ready_s = '0;
    rdy     = out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      rdy        = !valid_q[k] || rdy;
      ready_s[k] = rdy;
    end
  end

  // Slot next-state: load from upstream when ready, payload only on a valid block.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (ready_s[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = xform_s;
        tag_d[0]  = in_tag;
      end else begin
        data_d[0] = data_q[0];
        tag_d[0]  = tag_q[0];
      end
    end else begin
      valid_d[0] = valid_q[0];
    end
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (ready_s[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
          tag_d[k]  = tag_q[k-1];
        end else begin
          data_d[k] = data_q[k];
          tag_d[k]  = tag_q[k];
        end
      end else begin
        valid_d[k] = valid_q[k];
      end
    end
  end

  // Slot registers; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign in_ready  = ready_s[0];
  assign out_valid = valid_q[PIPE_STAGES-1];
  assign out_data  = data_q[PIPE_STAGES-1];
  assign out_tag   = tag_q[PIPE_STAGES-1];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench: an NB=4/1-stage instance for known vectors and an
// NB=8/3-stage instance for streaming, backpressure, ordering and reset.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic         a_in_valid = 1'b0, a_in_ready, a_in_inv = 1'b0;
  logic [127:0] a_in_data = '0, a_out_data;
  logic [3:0]   a_in_tag = '0, a_out_tag;
  logic         a_out_valid, a_out_ready = 1'b1, a_busy;

  logic         b_in_valid = 1'b0, b_in_ready, b_in_inv = 1'b0;
  logic [255:0] b_in_data = '0, b_out_data;
  logic [3:0]   b_in_tag = '0, b_out_tag;
  logic         b_out_valid, b_out_ready = 1'b1, b_busy;

  shift_rows_pipe #(.NB(4), .PIPE_STAGES(1), .TAG_W(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_inv(a_in_inv), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag), .busy(a_busy));

  shift_rows_pipe #(.NB(8), .PIPE_STAGES(3), .TAG_W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_inv(b_in_inv), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag), .busy(b_busy));

  // Reference: split each row out, rotate it, write it back.
  function automatic logic [255:0] ref_rows(input logic [255:0] d, input int nb, input bit inv);
    logic [7:0]   row [8];
    logic [7:0]   rot [8];
    logic [255:0] res;
    int bw, s;
    bw  = 32 * nb;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      s = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) row[c] = d[bw-1-8*(4*c+r) -: 8];
      for (int c = 0; c < nb; c++) begin
        if (inv) rot[(c + s) % nb] = row[c];
        else     rot[c] = row[(c + s) % nb];
      end
      for (int c = 0; c < nb; c++) res[bw-1-8*(4*c+r) -: 8] = rot[c];
    end
    return res;
  endfunction

  // One block through the 1-stage instance; also reports whether the
  // output slot kept its contents while garbage sat on idle inputs.
  task automatic a_xfer(input logic [127:0] d, input bit inv, input logic [3:0] tg,
                        output logic [127:0] od, output logic [3:0] ot,
                        output logic ov, output logic [127:0] held);
    @(negedge clk);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1; a_in_data = d; a_in_inv = inv; a_in_tag = tg;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    a_in_tag   = 4'($urandom());
    a_in_inv   = 1'($urandom());
    ov = a_out_valid; od = a_out_data; ot = a_out_tag;
    @(posedge clk);
    @(negedge clk);
    held = a_out_data;
  endtask

  // One block through the 3-stage instance, measuring acceptance-to-output cycles.
  task automatic b_single(input logic [255:0] d, input bit inv, input logic [3:0] tg,
                          output logic [255:0] od, output logic [3:0] ot, output int lat);
    @(negedge clk);
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1; b_in_data = d; b_in_inv = inv; b_in_tag = tg;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    b_in_valid = 1'b0;
    while (!b_out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    od = b_out_data; ot = b_out_tag;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_during: got %b want 1", a_in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid_busy: got %b%b want 00", a_out_valid, a_busy); end
    n_checks++; if (a_out_data !== 128'h0 || a_out_tag !== 4'h0) begin n_fail++; $display("FAIL rst_a_data_tag: got %h/%h want 0/0", a_out_data, a_out_tag); end
    n_checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_out_data !== 256'h0) begin n_fail++; $display("FAIL rst_b_state: got v=%b busy=%b d=%h want 0", b_out_valid, b_busy, b_out_data); end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_b_in_ready: got %b want 1", b_in_ready); end
  endtask

  task automatic test_forward_nb4;
    logic [127:0] od, held; logic [3:0] ot; logic ov;
    a_xfer(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 4'd3, od, ot, ov, held);
    n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL fwd4_valid: got %b want 1", ov); end
    n_checks++; if (od !== 128'h00050a0f04090e03080d02070c01060b) begin n_fail++; $display("FAIL fwd4_data: got %h want 00050a0f04090e03080d02070c01060b", od); end
    n_checks++; if (ot !== 4'd3) begin n_fail++; $display("FAIL fwd4_tag: got %0d want 3", ot); end
    n_checks++; if (held !== od || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got %h v=%b want %h v=0", held, a_out_valid, od); end
  endtask

  task automatic test_inverse_nb4;
    logic [127:0] od, od2, held; logic [3:0] ot; logic ov;
    a_xfer(128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'd9, od, ot, ov, held);
    n_checks++; if (od !== 128'h000d0a0704010e0b0805020f0c090603 || ot !== 4'd9) begin n_fail++; $display("FAIL inv4_data: got %h/%0d want 000d0a0704010e0b0805020f0c090603/9", od, ot); end
    a_xfer(od, 1'b0, 4'd1, od2, ot, ov, held);
    n_checks++; if (od2 !== 128'h000102030405060708090a0b0c0d0e0f) begin n_fail++; $display("FAIL inv4_roundtrip: got %h want 000102030405060708090a0b0c0d0e0f", od2); end
  endtask

  task automatic test_fips;
    logic [127:0] od, held, d, exp; logic [3:0] ot; logic ov; bit inv;
    logic [255:0] wide;
    a_xfer(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'd0, od, ot, ov, held);
    n_checks++; if (od !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin n_fail++; $display("FAIL fips_round1: got %h want d4bf5d30e0b452aeb84111f11e2798e5", od); end
    for (int i = 0; i < 4; i++) begin
      d    = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv  = (i % 2) == 1;
      wide = ref_rows({128'h0, d}, 4, inv);
      exp  = wide[127:0];
      a_xfer(d, inv, 4'(i), od, ot, ov, held);
      n_checks++; if (od !== exp || ot !== 4'(i)) begin n_fail++; $display("FAIL rand4_%0d: got %h/%0d want %h/%0d", i, od, ot, exp, i); end
    end
  endtask

  task automatic test_nb8;
    logic [255:0] d, od, od2; logic [3:0] ot; int lat;
    d = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    b_single(d, 1'b0, 4'd5, od, ot, lat);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL nb8_latency: got %0d want 3", lat); end
    n_checks++; if (od[255:224] !== 32'h00050e13) begin n_fail++; $display("FAIL nb8_col0: got %h want 00050e13", od[255:224]); end
    n_checks++; if (od[31:0] !== 32'h1c010a0f) begin n_fail++; $display("FAIL nb8_col7: got %h want 1c010a0f", od[31:0]); end
    n_checks++; if (od !== ref_rows(d, 8, 1'b0) || ot !== 4'd5) begin n_fail++; $display("FAIL nb8_full: got %h/%0d want %h/5", od, ot, ref_rows(d, 8, 1'b0)); end
    b_single(od, 1'b1, 4'd6, od2, ot, lat);
    n_checks++; if (od2 !== d) begin n_fail++; $display("FAIL nb8_roundtrip: got %h want %h", od2, d); end
  endtask

  task automatic test_back_to_back;
    logic [255:0] blk [8];
    logic [259:0] sb [$];
    logic [259:0] exp;
    logic [255:0] prev_data; logic [3:0] prev_tag;
    bit prev_stall, saw_bp, in_fire, out_fire, exp_rdy;
    int sent, got, occ, cyc;
    for (int k = 0; k < 8; k++)
      for (int w = 0; w < 8; w++) blk[k][32*w +: 32] = $urandom();
    sent = 0; got = 0; occ = 0; cyc = 0; prev_stall = 1'b0; saw_bp = 1'b0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      b_out_ready = !(cyc >= 4 && cyc <= 7);
      if (sent < 8) begin
        b_in_valid = 1'b1; b_in_data = blk[sent];
        b_in_inv = (sent % 2) == 1; b_in_tag = 4'(sent);
      end else begin
        b_in_valid = 1'b0;
      end
      #1;
      exp_rdy = !(occ == 3 && !b_out_ready);
      if (!exp_rdy) saw_bp = 1'b1;
      n_checks++; if (b_in_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_in_ready cyc%0d: got %b want %b", cyc, b_in_ready, exp_rdy); end
      if (prev_stall) begin
        n_checks++; if (b_out_data !== prev_data || b_out_tag !== prev_tag || b_out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_stable cyc%0d: got %h/%0d want %h/%0d", cyc, b_out_data, b_out_tag, prev_data, prev_tag); end
      end
      in_fire  = b_in_valid && b_in_ready;
      out_fire = b_out_valid && b_out_ready;
      if (out_fire) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_block: got tag %0d want none", b_out_tag);
        end else begin
          exp = sb.pop_front();
          if (b_out_data !== exp[255:0] || b_out_tag !== exp[259:256]) begin n_fail++; $display("FAIL b2b_order: got %h/%0d want %h/%0d", b_out_data, b_out_tag, exp[255:0], exp[259:256]); end
        end
        got++;
      end
      if (in_fire) begin
        sb.push_back({4'(sent), ref_rows(blk[sent], 8, (sent % 2) == 1)});
        sent++;
      end
      occ = occ + (in_fire ? 1 : 0) - (out_fire ? 1 : 0);
      prev_stall = b_out_valid && !b_out_ready;
      prev_data  = b_out_data; prev_tag = b_out_tag;
      cyc++;
      @(posedge clk);
    end
    @(negedge clk);
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    n_checks++; if (got != 8 || sb.size() != 0) begin n_fail++; $display("FAIL b2b_count: got %0d left %0d want 8 left 0", got, sb.size()); end
    n_checks++; if (!saw_bp) begin n_fail++; $display("FAIL b2b_backpressure: got none want in_ready low when full"); end
  endtask

  task automatic test_reset_midflight;
    logic [255:0] d, od; logic [3:0] ot; int lat;
    @(negedge clk);
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = {8{$urandom()}}; b_in_tag = 4'd1;
    @(posedge clk);
    @(negedge clk);
    b_in_data = {8{$urandom()}}; b_in_tag = 4'd2;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (b_out_valid !== 1'b1 || b_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got v=%b busy=%b want 11", b_out_valid, b_busy); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_flush: got v=%b busy=%b want 00", b_out_valid, b_busy); end
    n_checks++; if (b_out_data !== 256'h0 || b_out_tag !== 4'h0 || b_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_zero: got %h/%0d rdy=%b want 0/0 rdy=1", b_out_data, b_out_tag, b_in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    d = {8{$urandom()}};
    b_single(d, 1'b1, 4'd12, od, ot, lat);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL midrst_latency: got %0d want 3", lat); end
    n_checks++; if (od !== ref_rows(d, 8, 1'b1) || ot !== 4'd12) begin n_fail++; $display("FAIL midrst_data: got %h/%0d want %h/12", od, ot, ref_rows(d, 8, 1'b1)); end
    @(negedge clk);
    n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_no_stale: got busy=%b want 0", b_busy); end
  endtask

  initial begin
    test_reset();
    test_forward_nb4();
    test_inverse_nb4();
    test_fips();
    test_nb8();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Parametrised, pipelined Rijndael ShiftRows/InvShiftRows unit for the diffusion layer of the round datapath. It supports block widths of 128, 192 and 256 bits through the column count NB. Direction (forward or inverse) is selected per transaction. A valid/ready elastic pipeline of PIPE_STAGES registered slots carries a sideband tag alongside each block, so the encrypt and decrypt round controllers can share one instance under backpressure.

Parameters:
NB, 4, state columns; legal values 4, 6, 8. Block width BW = 32*NB.
PIPE_STAGES, 1, registered slots between input and output; legal values 1..4.
TAG_W, 4, width of the sideband tag carried with each block; legal values 1..16.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream block present
in_ready  output  1  unit can accept a block this cycle
in_data  input  BW  state block, column-major; byte i = in_data[BW-1-8i -: 8], column c = i/4, row r = i%4
in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data
in_tag  input  TAG_W  sideband, passed through unchanged
out_valid  output  1  output slot holds a block
out_ready  input  1  downstream accepts the block
out_data  output  BW  transformed block, same byte ordering as in_data
out_tag  output  TAG_W  tag of the block on out_data
busy  output  1  OR of all slot valid bits

Behaviour:
- Row offsets s(r):
  - NB = 4 or 6: s = {0,1,2,3}.
  - NB = 8: s = {0,1,3,4}.
- Forward: out byte (c,r) = in byte ((c + s(r)) mod NB, r).
- Inverse: out byte (c,r) = in byte ((c - s(r)) mod NB, r). Apply the modulo before indexing; there are no negative indices.
- Row 0 is always unchanged.
- The transform is combinational on the input side and is written into slot 1. Slots 2..PIPE_STAGES are plain register copies.
- Slot k holds valid_k, data_k and tag_k. The last slot drives out_valid, out_data and out_tag.
- Handshake:
  - A transfer occurs on the rising edge when valid and ready are both high, at input and at output.
  - ready_k = !valid_k | ready_(k+1), with ready_(PIPE_STAGES+1) = out_ready; in_ready = ready_1. This is a combinational ready chain and no bubbles are inserted.
  - Slot k loads from slot k-1 (slot 1 loads from the transform) when ready_k is high.
  - When slot k loads, valid_k takes the upstream valid. If ready_k is low, slot k holds.
- Throughput is one block per cycle when out_ready is held high.
- Latency is PIPE_STAGES cycles from input transfer to out_valid.
- Stall:
  - While out_valid=1 and out_ready=0, out_data and out_tag must stay stable.
  - in_ready falls only once every slot is valid.
- Simultaneous events: with a full pipe and out_ready=1, the input transfer and output transfer occur in the same cycle and no block is lost or duplicated.
- Ordering is strict FIFO. in_inv is per block, so mixed forward and inverse blocks stay in order.
- Reset (asynchronous assert, release on a clk edge): all valid_k=0, data_k=0, tag_k=0, so out_valid=0, out_data=0, out_tag=0, busy=0.
  - Reset mid-transfer discards all in-flight blocks.
  - in_ready is 1 while the pipe is empty, including during reset.
- When in_valid=0, in_data, in_inv and in_tag are don't-care and must not change slot contents.
- Illegal parameter values fail elaboration with a fatal message.

Test Plan:
1. NB=4, PIPE_STAGES=1, in_data=0x000102030405060708090a0b0c0d0e0f, in_inv=0, tag=3 -> one cycle later out_data=0x00050a0f04090e03080d02070c01060b, out_tag=3.
2. Same input with in_inv=1 -> out_data=0x000d0a0704010e0b0805020f0c090603. Feed that result back with in_inv=0 -> the original input is returned.
3. NB=4, FIPS-197 App. B round 1: in_data=0xd42711aee0bf98f1b8b45de51e415230, forward -> 0xd4bf5d30e0b452aeb84111f11e2798e5.
4. NB=8, input bytes 0x00..0x1f, forward:
   - out column 0 = 00 05 0e 13.
   - out column 7 = 1c 01 0a 0f.
   - Inverse of that output restores the input.
5. PIPE_STAGES=3, stream 8 blocks with tags 0..7 and alternating in_inv:
   - Hold out_ready=0 on cycles 4-7 -> in_ready=0 once 3 slots are full, and out_data stays stable during the stall.
   - Tags emerge 0..7 in order, none dropped or duplicated.
6. Assert rst for one cycle with 2 blocks in flight -> out_valid=0, busy=0, out_data=0 immediately. The next accepted block appears PIPE_STAGES cycles after acceptance.
